// File: rtl/sha3_pad_tx_if.sv
// Message-word ingress and 200-bit state-slice egress of the SHA3 padder.
interface sha3_pad_tx_if;
   logic [63:0]  msg_in;
   logic         msg_valid;
   logic         msg_last;
   logic [3:0]   msg_bytes;
   logic         msg_ready;
   logic [2:0]   dix;
   logic [199:0] din;
   logic         pushin;

   modport master (
      output msg_in, msg_valid, msg_last, msg_bytes,
      input  msg_ready, dix, din, pushin
   );

   modport slave (
      input  msg_in, msg_valid, msg_last, msg_bytes,
      output msg_ready, dix, din, pushin
   );
endinterface

// File: rtl/sha3_pad_tx.sv
// Collects a short message into a 1600-bit Keccak state, applies SHA3 padding and
// streams it as 8 x 200-bit slices; beat 0 two cycles after the final word, no output backpressure.
module sha3_pad_tx #(
   parameter int         RATE_BYTES = 136,
   parameter logic [7:0] DOMAIN_PAD = 8'h06
) (
   input  logic        clk,
   input  logic        reset,
   sha3_pad_tx_if.slave bus,
   output logic        busy,
   output logic        err
);
   localparam int WC_W  = $clog2(RATE_BYTES / 8 + 2);
   localparam int LEN_W = $clog2(RATE_BYTES);

   typedef enum logic [2:0] {IDLE, COLLECT, PAD, SEND, DROP} state_t;

   state_t           state_q;
   logic [1599:0]    buf_q;
   logic [1599:0]    buf_pad;
   logic [WC_W-1:0]  wc_q;
   logic [LEN_W-1:0] len_q;
   logic [2:0]       dix_q;
   logic [2:0]       dix_nxt;
   logic [199:0]     din_q;
   logic             pushin_q;
   logic             err_q;
   logic             msg_ready;
   logic             acc;
   logic [63:0]      wr_word;
   int               l_last;
   logic             over_last;
   logic             over_mid;

   assign msg_ready     = (state_q == IDLE) || (state_q == COLLECT) || (state_q == DROP);
   assign acc           = bus.msg_valid && msg_ready;
   assign bus.msg_ready = msg_ready;
   assign bus.dix       = dix_q;
   assign bus.din       = din_q;
   assign bus.pushin    = pushin_q;
   assign busy          = (state_q != IDLE);
   assign err           = err_q;
   assign dix_nxt       = dix_q + 3'd1;

   // Final-word length check: anything reaching the rate, or a bogus byte count, is dropped.
   always_comb begin
      l_last    = int'(wc_q) * 8 + int'(bus.msg_bytes);
      over_last = (bus.msg_bytes > 4'd8) || (l_last >= RATE_BYTES);
      over_mid  = ((int'(wc_q) + 1) * 8) >= RATE_BYTES;
   end

   always_comb begin
      wr_word = '0;
      for (int i = 0; i < 8; i++) begin
         if (!bus.msg_last || (i < int'(bus.msg_bytes)))
            wr_word[8*i +: 8] = bus.msg_in[8*i +: 8];
      end
   end

   // Both pad bytes are XORed so L = RATE_BYTES-1 folds into a single byte.
   always_comb begin
      buf_pad = buf_q;
      buf_pad[{len_q, 3'b000} +: 8]     = buf_pad[{len_q, 3'b000} +: 8] ^ DOMAIN_PAD;
      buf_pad[8*(RATE_BYTES-1) +: 8]    = buf_pad[8*(RATE_BYTES-1) +: 8] ^ 8'h80;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         buf_q    <= '0;
         wc_q     <= '0;
         len_q    <= '0;
         dix_q    <= '0;
         din_q    <= '0;
         pushin_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE, COLLECT: begin
               if (acc) begin
                  if (bus.msg_last) begin
                     if (over_last) begin
                        err_q   <= 1'b1;
                        buf_q   <= '0;
                        wc_q    <= '0;
                        state_q <= IDLE;
                     end else begin
                        buf_q[{wc_q, 6'b000000} +: 64] <= wr_word;
                        len_q   <= LEN_W'(l_last);
                        state_q <= PAD;
                     end
                  end else if (over_mid) begin
                     state_q <= DROP;
                  end else begin
                     buf_q[{wc_q, 6'b000000} +: 64] <= wr_word;
                     wc_q    <= wc_q + 1'b1;
                     state_q <= COLLECT;
                  end
               end
            end
            DROP: begin
               if (acc && bus.msg_last) begin
                  err_q   <= 1'b1;
                  buf_q   <= '0;
                  wc_q    <= '0;
                  state_q <= IDLE;
               end
            end
            PAD: begin
               buf_q    <= buf_pad;
               din_q    <= buf_pad[199:0];
               dix_q    <= 3'd0;
               pushin_q <= 1'b1;
               state_q  <= SEND;
            end
            SEND: begin
               if (dix_q == 3'd7) begin
                  pushin_q <= 1'b0;
                  dix_q    <= 3'd0;
                  din_q    <= '0;
                  buf_q    <= '0;
                  wc_q     <= '0;
                  len_q    <= '0;
                  state_q  <= IDLE;
               end else begin
                  dix_q <= dix_nxt;
                  din_q <= buf_q[int'(dix_nxt)*200 +: 200];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha3_pad_tx.sv
// Directed bench for sha3_pad_tx: known padded slices, latency, drop, back-to-back and reset-abort.
module tb_sha3_pad_tx;
   logic clk;
   logic reset;
   logic busy;
   logic err;
   int   checks;
   int   failures;
   int   cyc;

   sha3_pad_tx_if bus();

   sha3_pad_tx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Beat and error log, sampled mid-cycle.
   int           beat_n;
   logic [2:0]   beat_dix [64];
   logic [199:0] beat_din [64];
   int           beat_cyc [64];
   int           err_n;
   int           err_cyc;

   always @(negedge clk) begin
      if (bus.pushin === 1'b1 && beat_n < 64) begin
         beat_dix[beat_n] = bus.dix;
         beat_din[beat_n] = bus.din;
         beat_cyc[beat_n] = cyc;
         beat_n = beat_n + 1;
      end
      if (err === 1'b1) begin
         err_n   = err_n + 1;
         err_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns the cycle stamp at which the word was taken.
   task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb,
                            output int acc);
      bus.msg_in    = d;
      bus.msg_last  = l;
      bus.msg_bytes = nb;
      bus.msg_valid = 1'b1;
      acc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.msg_ready === 1'b1) begin
            acc = cyc;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.msg_valid = 1'b0;
      bus.msg_last  = 1'b0;
      if (acc < 0) check("accept_timeout", 200'd0, 200'd1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_msg(input string tag, input int first, input int acc,
                            input logic [199:0] e0, input logic [199:0] e5,
                            input logic [199:0] eo);
      logic [199:0] e;
      check({tag, "_beat0_cyc"}, 200'(beat_cyc[first]), 200'(acc + 2));
      check({tag, "_beat7_cyc"}, 200'(beat_cyc[first+7]), 200'(acc + 9));
      for (int i = 0; i < 8; i++) begin
         e = (i == 0) ? e0 : (i == 5) ? e5 : eo;
         check($sformatf("%s_dix%0d", tag, i), 200'(beat_dix[first+i]), 200'(i));
         check($sformatf("%s_din%0d", tag, i), beat_din[first+i], e);
      end
   endtask

   localparam logic [199:0] PAD80 = 200'h80 << 80;
   localparam logic [199:0] ONES  = {200{1'b1}};

   initial begin
      int a;
      int a2;
      checks = 0; failures = 0; cyc = 0;
      beat_n = 0; err_n = 0; err_cyc = -1;
      reset = 1'b1;
      bus.msg_in = '0; bus.msg_valid = 1'b0; bus.msg_last = 1'b0; bus.msg_bytes = '0;
      idle_cycles(3);

      // Reset state, with a word offered during reset that must not be taken.
      bus.msg_valid = 1'b1; bus.msg_last = 1'b1; bus.msg_bytes = 4'd3; bus.msg_in = 64'h636261;
      idle_cycles(1);
      bus.msg_valid = 1'b0; bus.msg_last = 1'b0;
      check("rst_ready",  200'(bus.msg_ready), 200'd1);
      check("rst_pushin", 200'(bus.pushin), 200'd0);
      check("rst_dix",    200'(bus.dix), 200'd0);
      check("rst_din",    bus.din, 200'd0);
      check("rst_busy",   200'(busy), 200'd0);
      check("rst_err",    200'(err), 200'd0);
      reset = 1'b0;
      idle_cycles(3);
      check("rst_no_beats", 200'(beat_n), 200'd0);

      // Empty message.
      beat_n = 0;
      send_word(64'hDEAD_BEEF_0000_0000, 1'b1, 4'd0, a);
      idle_cycles(12);
      check("empty_nbeats", 200'(beat_n), 200'd8);
      check_msg("empty", 0, a, 200'h06, PAD80, 200'd0);
      check("idle_pushin", 200'(bus.pushin), 200'd0);
      check("idle_din",    bus.din, 200'd0);
      check("idle_busy",   200'(busy), 200'd0);

      // "abc".
      beat_n = 0;
      send_word(64'hFFFF_FFFF_FF63_6261, 1'b1, 4'd3, a);
      idle_cycles(12);
      check("abc_nbeats", 200'(beat_n), 200'd8);
      check_msg("abc", 0, a, 200'h06636261, PAD80, 200'd0);

      // 135 bytes of 0xFF: both pad bytes land on byte 135.
      beat_n = 0;
      for (int w = 0; w < 16; w++) send_word({64{1'b1}}, 1'b0, 4'd8, a);
      send_word({64{1'b1}}, 1'b1, 4'd7, a);
      idle_cycles(12);
      check("l135_nbeats", 200'(beat_n), 200'd8);
      for (int i = 0; i < 5; i++)
         check($sformatf("l135_din%0d", i), beat_din[i], ONES);
      check("l135_din5", beat_din[5], (200'h86 << 80) | ((200'd1 << 80) - 200'd1));
      check("l135_din6", beat_din[6], 200'd0);
      check("l135_din7", beat_din[7], 200'd0);
      check("l135_no_err", 200'(err_n), 200'd0);

      // 136 bytes: dropped, single err pulse one cycle after the final word.
      beat_n = 0; err_n = 0;
      for (int w = 0; w < 16; w++) send_word(64'h0123_4567_89AB_CDEF, 1'b0, 4'd8, a);
      send_word(64'h0123_4567_89AB_CDEF, 1'b1, 4'd8, a);
      idle_cycles(12);
      check("l136_nbeats", 200'(beat_n), 200'd0);
      check("l136_err_n",  200'(err_n), 200'd1);
      check("l136_err_cyc", 200'(err_cyc), 200'(a + 1));
      beat_n = 0;
      send_word(64'h636261, 1'b1, 4'd3, a);
      idle_cycles(12);
      check("post_drop_nbeats", 200'(beat_n), 200'd8);
      check_msg("post_drop", 0, a, 200'h06636261, PAD80, 200'd0);

      // Oversized byte count on a single word.
      beat_n = 0; err_n = 0;
      send_word(64'h11, 1'b1, 4'd9, a);
      idle_cycles(12);
      check("nb9_nbeats", 200'(beat_n), 200'd0);
      check("nb9_err_n",  200'(err_n), 200'd1);

      // Back-to-back "abc" with valid held.
      beat_n = 0;
      send_word(64'h636261, 1'b1, 4'd3, a);
      fork
         send_word(64'h636261, 1'b1, 4'd3, a2);
         begin
            repeat (4) @(negedge clk);
            check("b2b_ready_low", 200'(bus.msg_ready), 200'd0);
            check("b2b_busy",      200'(busy), 200'd1);
         end
      join
      idle_cycles(12);
      check("b2b_nbeats", 200'(beat_n), 200'd16);
      check("b2b_gap", 200'(a2 - a), 200'd10);
      check_msg("b2b_1", 0, a, 200'h06636261, PAD80, 200'd0);
      check_msg("b2b_2", 8, a2, 200'h06636261, PAD80, 200'd0);

      // Reset in the middle of a burst.
      beat_n = 0;
      send_word(64'h0, 1'b1, 4'd0, a);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.pushin === 1'b1 && bus.dix === 3'd3) break;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst3_pushin", 200'(bus.pushin), 200'd0);
      check("rst3_busy",   200'(busy), 200'd0);
      check("rst3_ready",  200'(bus.msg_ready), 200'd1);
      idle_cycles(10);
      check("rst3_nbeats", 200'(beat_n), 200'd4);
      beat_n = 0;
      send_word(64'h0, 1'b1, 4'd0, a);
      idle_cycles(12);
      check("rst3_empty_nbeats", 200'(beat_n), 200'd8);
      check_msg("rst3_empty", 0, a, 200'h06, PAD80, 200'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
